// File: rtl/bram_pixel_writer.sv
// Packs a byte-serial R,G,B stream into {8'h00,R,G,B} words and writes them to
// sequential BRAM word addresses, pulsing frame_done once the frame is committed.
module bram_pixel_writer #(
    parameter int NUM_PIXELS = 7056,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              busy,
    output logic              frame_done,
    output logic              err_short,
    output logic              err_long,
    output logic [ADDR_W-1:0] pixel_count,
    output logic              clka,
    output logic              rsta,
    output logic              ena,
    output logic [31:0]       addra,
    output logic [31:0]       dina,
    output logic [3:0]        wea,
    input  logic [31:0]       douta
);
    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE_LAST, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    state_t            r_state, w_next;
    logic [1:0]        r_phase;
    logic [7:0]        r_red, r_grn;
    logic [31:0]       r_wdata;
    logic              r_wr;
    logic [ADDR_W-1:0] r_count;
    logic              r_err_short, r_err_long;

    logic w_acc, w_b, w_final, w_early, w_unused;

    assign w_acc   = s_valid && s_ready;
    assign w_b     = w_acc && (r_phase == 2'd2);
    // r_count already equals the index of the pixel whose B byte is arriving:
    // the previous write has always retired by then.
    assign w_final = w_b && (r_count == LAST_IDX);
    assign w_early = w_acc && s_last && !w_final;
    assign w_unused = ^douta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (start) w_next = CAPTURE;
            CAPTURE: begin
                if (w_final || (w_early && w_b)) w_next = WRITE_LAST;
                else if (w_early)                w_next = DONE;
            end
            WRITE_LAST: w_next = DONE;
            DONE:       w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready    = (r_state == CAPTURE);
        busy       = (r_state != IDLE);
        frame_done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase     <= 2'd0;
            r_red       <= 8'h00;
            r_grn       <= 8'h00;
            r_wdata     <= 32'h0;
            r_wr        <= 1'b0;
            r_count     <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_wr <= w_b;
            if (r_wr) r_count <= r_count + ADDR_W'(1);
            if (w_acc) begin
                case (r_phase)
                    2'd0: begin r_red <= s_data; r_phase <= 2'd1; end
                    2'd1: begin r_grn <= s_data; r_phase <= 2'd2; end
                    default: begin
                        r_wdata <= {8'h00, r_red, r_grn, s_data};
                        r_phase <= 2'd0;
                    end
                endcase
            end
            if (w_early)            r_err_short <= 1'b1;
            if (w_final && !s_last) r_err_long  <= 1'b1;
            if (r_state == IDLE && start) begin
                r_phase     <= 2'd0;
                r_count     <= '0;
                r_err_short <= 1'b0;
                r_err_long  <= 1'b0;
            end
        end
    end

    assign pixel_count = r_count;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;
    assign clka        = clk;
    assign rsta        = ~rstn;
    assign ena         = r_wr;
    assign wea         = {4{r_wr}};
    assign addra       = r_wr ? {{(30-ADDR_W){1'b0}}, r_count, 2'b00} : 32'h0;
    assign dina        = r_wr ? r_wdata : 32'h0;
endmodule

// File: tb/tb_bram_pixel_writer.sv
// Directed bench for bram_pixel_writer: full frames, gapped stream, early and
// missing s_last, mid-frame reset and ignored start pulses.
module tb_bram_pixel_writer;
    localparam int NP = 7056;
    localparam int NB = 3 * NP;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rstn, start, s_valid, s_last;
    logic [7:0]    s_data;
    logic          s_ready, busy, frame_done, err_short, err_long;
    logic [AW-1:0] pixel_count;
    logic          clka, rsta, ena;
    logic [31:0]   addra, dina, douta;
    logic [3:0]    wea;

    bram_pixel_writer #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .busy(busy), .frame_done(frame_done),
        .err_short(err_short), .err_long(err_long), .pixel_count(pixel_count),
        .clka(clka), .rsta(rsta), .ena(ena), .addra(addra), .dina(dina),
        .wea(wea), .douta(douta)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Write monitor: sole owner of the captured memory image and event counters.
    logic [31:0] mem [NP];
    int          mem_frame [NP];
    int          frame_id = 0;
    int          wr_cnt = 0, fd_cnt = 0, consec = 0, bad_we = 0, bad_addr = 0;
    time         fd_t = 0;
    logic        prev_ena = 1'b0;

    always @(negedge clk) begin
        if (ena) begin
            wr_cnt++;
            if (wea !== 4'hF) bad_we++;
            if (prev_ena) consec++;
            if (addra[31:2] >= 30'(NP) || addra[1:0] != 2'b00) bad_addr++;
            else begin
                mem[addra[14:2]]       = dina;
                mem_frame[addra[14:2]] = frame_id;
            end
        end else if (wea !== 4'h0) bad_we++;
        prev_ena = ena;
        if (frame_done) begin fd_cnt++; fd_t = $time; end
    end

    int  base_wr, base_fd, base_consec, base_bad;
    time acc_t, first_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        frame_id++;
        base_wr     = wr_cnt;
        base_fd     = fd_cnt;
        base_consec = consec;
        base_bad    = bad_we + bad_addr;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input int k, input logic l, input int gap);
        int   n;
        logic rdy;
        while (int'($urandom_range(99)) < gap) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = 8'(k); s_last = l;
        n = 0;
        do begin
            rdy = s_ready;
            @(posedge clk);
            acc_t = $time;
            #1;
            n++;
        end while (!rdy && n < 64);
        if (!rdy) begin
            errors++;
            $display("FAIL handshake_timeout: byte %0d never accepted, observed s_ready=0 expected 1", k);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "stream stalled");
        end
        if (k == 0) first_t = acc_t;
    endtask

    // Bytes k = first..last with value k mod 256; s_last on byte last_at; start held during byte start_at.
    task automatic send_range(input int last_k, input int last_at, input int gap, input int start_at);
        for (int k = 0; k <= last_k; k++) begin
            start = (k == start_at);
            send_byte(k, k == last_at, gap);
        end
        start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    endtask

    function automatic int image_bad(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (mem_frame[i] != frame_id ||
                mem[i] !== {8'h00, 8'(3*i), 8'(3*i+1), 8'(3*i+2)}) bad++;
        return bad;
    endfunction

    initial begin
        rstn = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; douta = 32'h0;
        for (int i = 0; i < NP; i++) begin mem[i] = 32'hDEADBEEF; mem_frame[i] = 0; end
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {frame_done, err_short, err_long, ena, wea}, 0);
        chk("rst_pixel_count", pixel_count, 0);
        chk("rst_addr_data", {addra, dina}, 0);
        chk("rst_rsta", rsta, 1);
        @(posedge clk); #2; rstn = 1'b1;
        @(posedge clk); #1;

        // Full frame, continuous stream, s_last on byte 21167
        snap();
        pulse_start();
        chk("s1_busy_after_start", busy, 1);
        send_range(NB-1, NB-1, 0, -1);
        chk("s1_s_ready_drops", s_ready, 0);
        repeat (3) @(posedge clk); #1;
        chk("s1_writes", wr_cnt - base_wr, NP);
        chk("s1_image", image_bad(NP), 0);
        chk("s1_done_latency", fd_t - acc_t, 15);
        chk("s1_done_pulses", fd_cnt - base_fd, 1);
        chk("s1_no_bubbles", acc_t - first_t, (NB-1)*10);
        chk("s1_no_consec", consec - base_consec, 0);
        chk("s1_we_addr_ok", bad_we + bad_addr - base_bad, 0);
        chk("s1_errors", {err_short, err_long}, 0);
        chk("s1_pixel_count", pixel_count, NP);

        // Missing s_last, start pulsed at pixel 10 and again during DONE
        snap();
        pulse_start();
        send_range(NB-1, -1, 0, 30);
        @(posedge clk); #1;
        chk("s6_in_done", frame_done, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("s6_idle_after_done", busy, 0);
        repeat (2) @(posedge clk); #1;
        chk("s6_start_ignored", {busy, s_ready}, 0);
        chk("s4_err_long", err_long, 1);
        chk("s4_err_short", err_short, 0);
        chk("s4_writes", wr_cnt - base_wr, NP);
        chk("s4_image", image_bad(NP), 0);
        chk("s4_done_pulses", fd_cnt - base_fd, 1);
        chk("s4_pixel_count", pixel_count, NP);
        pulse_start();
        chk("s4_start_clears", {err_long, err_short}, 0);
        chk("s4_count_cleared", pixel_count, 0);

        // s_last on the G byte of pixel 99 (capture already armed above)
        snap();
        send_range(298, 298, 0, -1);
        chk("s3_s_ready_drops", s_ready, 0);
        repeat (3) @(posedge clk); #1;
        chk("s3_done_latency", fd_t - acc_t, 5);
        chk("s3_writes", wr_cnt - base_wr, 99);
        chk("s3_image", image_bad(99), 0);
        chk("s3_no_partial", mem_frame[99] == frame_id, 0);
        chk("s3_err_short", err_short, 1);
        chk("s3_pixel_count", pixel_count, 99);
        chk("s3_idle", {busy, s_ready}, 0);

        // Reset right after the B byte of pixel 500, then a gapped full frame
        snap();
        pulse_start();
        send_range(1502, -1, 0, -1);
        rstn = 1'b0;
        #1;
        chk("s5_rst_ctrl", {s_ready, busy, frame_done, ena, wea}, 0);
        chk("s5_rst_data", {addra, dina}, 0);
        chk("s5_rst_count", pixel_count, 0);
        repeat (3) @(posedge clk); #1;
        rstn = 1'b1;
        chk("s5_writes_before_rst", wr_cnt - base_wr, 500);
        chk("s5_pixel500_dropped", mem_frame[500] == frame_id, 0);
        @(posedge clk); #1;
        snap();
        pulse_start();
        send_range(NB-1, NB-1, 35, -1);
        repeat (3) @(posedge clk); #1;
        chk("s2_writes", wr_cnt - base_wr, NP);
        chk("s2_image", image_bad(NP), 0);
        chk("s2_no_consec", consec - base_consec, 0);
        chk("s2_we_addr_ok", bad_we + bad_addr - base_bad, 0);
        chk("s2_done_latency", fd_t - acc_t, 15);
        chk("s2_errors", {err_short, err_long}, 0);
        chk("s2_pixel_count", pixel_count, NP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
